instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 23 ++
 rtl/instr_word_build.sv | 27 ++
 rtl/instr_encoder.sv | 111 +++++++++++
 tb/tb_instr_encoder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: instruction kinds, opcode/funct constants and encoder FSM state type
package instr_encoder_pkg;
    localparam logic [2:0] KIND_R    = 3'd0;
    localparam logic [2:0] KIND_ADDI = 3'd1;
    localparam logic [2:0] KIND_LW   = 3'd2;
    localparam logic [2:0] KIND_SW   = 3'd3;
    localparam logic [2:0] KIND_ANDI = 3'd4;
    localparam logic [2:0] KIND_BEQ  = 3'd5;
    localparam logic [2:0] KIND_JAL  = 3'd6;
    localparam logic [2:0] KIND_ILL  = 3'd7;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    typedef enum logic [1:0] {IDLE, ENCODE, WRITE, ERR} state_t;
endpackage

// File: rtl/instr_word_build.sv
// instr_word_build: combinational mapping of captured instruction fields to {word, legal}
module instr_word_build import instr_encoder_pkg::*; (
    input  logic [2:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);
    logic [5:0] op;
    logic       funct_ok;
    always_comb begin
        op = kind == KIND_ADDI ? OP_ADDI :
             kind == KIND_LW   ? OP_LW   :
             kind == KIND_SW   ? OP_SW   :
             kind == KIND_ANDI ? OP_ANDI :
             kind == KIND_BEQ  ? OP_BEQ  : 6'b000000;
        funct_ok = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
        word = kind == KIND_R   ? {6'b000000, rs, rt, rd, shamt, funct} :
               kind == KIND_JAL ? {OP_JAL, target} : {op, rs, rt, imm};
        legal = kind == KIND_R ? funct_ok : kind != KIND_ILL;
    end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: captures instruction fields, encodes them and writes one word per request to instruction memory
module instr_encoder import instr_encoder_pkg::*; #(
    parameter int          COUNT_W    = 8,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_kind,
    input  logic [4:0]         in_rs,
    input  logic [4:0]         in_rt,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_shamt,
    input  logic [5:0]         in_funct,
    input  logic [15:0]        in_imm,
    input  logic [25:0]        in_target,
    input  logic               load_start,
    input  logic [31:0]        start_addr,
    output logic               mem_we,
    output logic [31:0]        mem_addr,
    output logic [31:0]        mem_wdata,
    output logic               busy,
    output logic               error,
    output logic [COUNT_W-1:0] count
);
    state_t      state;
    logic [2:0]  kind_q;
    logic [4:0]  rs_q;
    logic [4:0]  rt_q;
    logic [4:0]  rd_q;
    logic [4:0]  shamt_q;
    logic [5:0]  funct_q;
    logic [15:0] imm_q;
    logic [25:0] target_q;
    logic [31:0] addr;
    logic [31:0] word;
    logic        legal;
    assign in_ready = state == IDLE && !load_start;
    assign busy     = state != IDLE;
    instr_word_build u_build (
        .kind   (kind_q),
        .rs     (rs_q),
        .rt     (rt_q),
        .rd     (rd_q),
        .shamt  (shamt_q),
        .funct  (funct_q),
        .imm    (imm_q),
        .target (target_q),
        .word   (word),
        .legal  (legal)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= RESET_ADDR;
            mem_wdata <= 32'd0;
            addr      <= RESET_ADDR;
            count     <= '0;
            error     <= 1'b0;
            kind_q    <= 3'd0;
            rs_q      <= 5'd0;
            rt_q      <= 5'd0;
            rd_q      <= 5'd0;
            shamt_q   <= 5'd0;
            funct_q   <= 6'd0;
            imm_q     <= 16'd0;
            target_q  <= 26'd0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        addr  <= start_addr & ~32'd3;
                        count <= '0;
                        error <= 1'b0;
                    end else if (in_valid) begin
                        kind_q   <= in_kind;
                        rs_q     <= in_rs;
                        rt_q     <= in_rt;
                        rd_q     <= in_rd;
                        shamt_q  <= in_shamt;
                        funct_q  <= in_funct;
                        imm_q    <= in_imm;
                        target_q <= in_target;
                        state    <= ENCODE;
                    end
                end
                ENCODE: begin
                    state <= legal ? WRITE : ERR;
                    if (legal) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr;
                        mem_wdata <= word;
                    end
                end
                WRITE: begin
                    addr  <= addr + 32'd4;
                    count <= &count ? count : count + 1'b1;
                    state <= IDLE;
                end
                ERR: begin
                    error <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors with hand-computed encodings for instr_encoder
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_kind = 3'd0;
    logic [4:0]  in_rs = 5'd0;
    logic [4:0]  in_rt = 5'd0;
    logic [4:0]  in_rd = 5'd0;
    logic [4:0]  in_shamt = 5'd0;
    logic [5:0]  in_funct = 6'd0;
    logic [15:0] in_imm = 16'd0;
    logic [25:0] in_target = 26'd0;
    logic        load_start = 1'b0;
    logic [31:0] start_addr = 32'd0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        error;
    logic [7:0]  count;
    int vectors = 0;
    int miscompares = 0;

    instr_encoder #(.COUNT_W(8), .RESET_ADDR(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_shamt   (in_shamt),
        .in_funct   (in_funct),
        .in_imm     (in_imm),
        .in_target  (in_target),
        .load_start (load_start),
        .start_addr (start_addr),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .error      (error),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic set_fields(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                              input logic [15:0] im, input logic [25:0] tg);
        in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_funct = fn; in_imm = im; in_target = tg;
    endtask

    task automatic send(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                        input logic [15:0] im, input logic [25:0] tg);
        set_fields(k, rs, rt, rd, sh, fn, im, tg);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load(input logic [31:0] a);
        start_addr = a;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_we got %0b want 0", mem_we); end
        vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr got %h want 00000000", mem_addr); end
        vectors++; if (mem_wdata !== 32'h0) begin miscompares++; $display("FAIL rst_wdata got %h want 00000000", mem_wdata); end
        vectors++; if ({busy, error, count} !== 10'd0) begin miscompares++; $display("FAIL rst_flags busy=%0b error=%0b count=%0d want 0 0 0", busy, error, count); end
        rst = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %0b want 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_addi;
        load(32'h100);
        send(3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0);
        vectors++; if ({busy, in_ready, mem_we} !== 3'b100) begin miscompares++; $display("FAIL addi_encode busy/ready/we got %b want 100", {busy, in_ready, mem_we}); end
        @(negedge clk);
        vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL addi_we got %0b want 1", mem_we); end
        vectors++; if (mem_addr !== 32'h100) begin miscompares++; $display("FAIL addi_addr got %h want 00000100", mem_addr); end
        vectors++; if (mem_wdata !== 32'h20220005) begin miscompares++; $display("FAIL addi_word got %h want 20220005", mem_wdata); end
        @(negedge clk);
        vectors++; if ({mem_we, in_ready} !== 2'b01) begin miscompares++; $display("FAIL addi_after we/ready got %b want 01", {mem_we, in_ready}); end
        vectors++; if (count !== 8'd1) begin miscompares++; $display("FAIL addi_count got %0d want 1", count); end
        vectors++; if (mem_addr !== 32'h100) begin miscompares++; $display("FAIL addi_addr_hold got %h want 00000100", mem_addr); end
    endtask

    task automatic test_back_to_back;
        send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000, 16'd0, 26'd0);
        set_fields(3'd2, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'd4, 26'd0);
        in_valid = 1'b1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_encode got %0b want 0", in_ready); end
        @(negedge clk);
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_write got %0b want 0", in_ready); end
        vectors++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h104, 32'h00221820}) begin miscompares++; $display("FAIL b2b_r we=%0b addr=%h data=%h want 1 00000104 00221820", mem_we, mem_addr, mem_wdata); end
        @(negedge clk);
        vectors++; if ({in_ready, mem_we} !== 2'b10) begin miscompares++; $display("FAIL b2b_idle ready/we got %b want 10", {in_ready, mem_we}); end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        vectors++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h108, 32'h8FA80004}) begin miscompares++; $display("FAIL b2b_lw we=%0b addr=%h data=%h want 1 00000108 8fa80004", mem_we, mem_addr, mem_wdata); end
        @(negedge clk);
        vectors++; if (count !== 8'd3) begin miscompares++; $display("FAIL b2b_count got %0d want 3", count); end
    endtask

    task automatic test_jal;
        send(3'd6, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000010);
        @(negedge clk);
        vectors++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h10C, 32'h0C000010}) begin miscompares++; $display("FAIL jal we=%0b addr=%h data=%h want 1 0000010c 0c000010", mem_we, mem_addr, mem_wdata); end
        @(negedge clk);
    endtask

    task automatic test_illegal;
        send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b000111, 16'd0, 26'd0);
        @(negedge clk);
        vectors++; if ({mem_we, busy} !== 2'b01) begin miscompares++; $display("FAIL ill_err we/busy got %b want 01", {mem_we, busy}); end
        @(negedge clk);
        vectors++; if ({mem_we, error, count} !== {1'b0, 1'b1, 8'd4}) begin miscompares++; $display("FAIL ill_after we=%0b error=%0b count=%0d want 0 1 4", mem_we, error, count); end
        vectors++; if (mem_addr !== 32'h10C) begin miscompares++; $display("FAIL ill_addr_hold got %h want 0000010c", mem_addr); end
        send(3'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
        @(negedge clk);
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL ill7_we got %0b want 0", mem_we); end
        @(negedge clk);
        send(3'd3, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0);
        @(negedge clk);
        vectors++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h110, 32'hAC64FFFF}) begin miscompares++; $display("FAIL sw we=%0b addr=%h data=%h want 1 00000110 ac64ffff", mem_we, mem_addr, mem_wdata); end
        @(negedge clk);
        send(3'd5, 5'd5, 5'd6, 5'd0, 5'd0, 6'd0, 16'hFFFE, 26'd0);
        @(negedge clk);
        vectors++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h114, 32'h10A6FFFE}) begin miscompares++; $display("FAIL beq we=%0b addr=%h data=%h want 1 00000114 10a6fffe", mem_we, mem_addr, mem_wdata); end
        @(negedge clk);
        vectors++; if ({error, count} !== {1'b1, 8'd6}) begin miscompares++; $display("FAIL sticky error=%0b count=%0d want 1 6", error, count); end
    endtask

    task automatic test_wrap;
        load(32'hFFFF_FFFC);
        vectors++; if ({error, count} !== 9'd0) begin miscompares++; $display("FAIL load_clear error=%0b count=%0d want 0 0", error, count); end
        send(3'd4, 5'd7, 5'd8, 5'd0, 5'd0, 6'd0, 16'h00FF, 26'd0);
        @(negedge clk);
        vectors++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'hFFFFFFFC, 32'h30E800FF}) begin miscompares++; $display("FAIL wrap1 we=%0b addr=%h data=%h want 1 fffffffc 30e800ff", mem_we, mem_addr, mem_wdata); end
        @(negedge clk);
        send(3'd4, 5'd7, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0F0F, 26'd0);
        @(negedge clk);
        vectors++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h0, 32'h30E80F0F}) begin miscompares++; $display("FAIL wrap2 we=%0b addr=%h data=%h want 1 00000000 30e80f0f", mem_we, mem_addr, mem_wdata); end
        @(negedge clk);
        vectors++; if (count !== 8'd2) begin miscompares++; $display("FAIL wrap_count got %0d want 2", count); end
    endtask

    task automatic test_load_priority;
        start_addr = 32'h203;
        load_start = 1'b1;
        set_fields(3'd1, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'd1, 26'd0);
        in_valid = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL prio_ready got %0b want 0", in_ready); end
        @(negedge clk);
        load_start = 1'b0;
        in_valid = 1'b0;
        vectors++; if ({busy, count} !== 9'd0) begin miscompares++; $display("FAIL prio_noaccept busy=%0b count=%0d want 0 0", busy, count); end
        send(3'd6, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h3FFFFFF);
        start_addr = 32'h400;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        vectors++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h200, 32'h0FFFFFFF}) begin miscompares++; $display("FAIL prio_write we=%0b addr=%h data=%h want 1 00000200 0fffffff", mem_we, mem_addr, mem_wdata); end
        @(negedge clk);
        vectors++; if (count !== 8'd1) begin miscompares++; $display("FAIL busy_load_ignored count got %0d want 1", count); end
    endtask

    task automatic test_reset_mid;
        send(3'd1, 5'd9, 5'd9, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy got %0b want 1", busy); end
        rst = 1'b1;
        #1;
        vectors++; if ({busy, mem_we, error, count} !== 11'd0) begin miscompares++; $display("FAIL mid_async busy=%0b we=%0b error=%0b count=%0d want 0 0 0 0", busy, mem_we, error, count); end
        vectors++; if ({mem_addr, mem_wdata} !== 64'd0) begin miscompares++; $display("FAIL mid_async addr=%h data=%h want 00000000 00000000", mem_addr, mem_wdata); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++; if ({mem_we, count} !== 9'd0) begin miscompares++; $display("FAIL mid_nowrite cycle %0d we=%0b count=%0d want 0 0", i, mem_we, count); end
        end
    endtask

    initial begin
        test_reset;
        test_addi;
        test_back_to_back;
        test_jal;
        test_illegal;
        test_wrap;
        test_load_priority;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
